dest_reg_scoreboard: RTL and testbench

Tracks which architectural registers have a write in flight between issue and write-back. It consumes the 5-bit destination index chosen by the RegDst select path, decodes it to a 32-entry pending mask, and stalls issue on RAW hazards against source registers. Sits beside the ID stage: issue sets, WB clears, and the Stall output gates the PC and IF/ID write enables.

---
 rtl/dest_reg_scoreboard_pkg.sv | 12 +
 rtl/dest_reg_scoreboard_decoder.sv | 21 ++
 rtl/dest_reg_scoreboard.sv | 131 +++++++++++++
 tb/tb_dest_reg_scoreboard.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dest_reg_scoreboard_pkg.sv
// Shared constants and types for the destination-register scoreboard.
// Optional feature macro: SCOREBOARD_MULTI_PENDING_EN (per-register counters).
package scoreboard_pkg;

   localparam int NUM_REGS    = 32;
   localparam int IDX_W       = 5;
   localparam int MAX_PENDING = 3;
   localparam int CNT_W       = $clog2(MAX_PENDING + 1);

   typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/dest_reg_scoreboard_decoder.sv
// Register index plus enable to a one-hot register mask.
module reg_idx_decoder_5to32
   import scoreboard_pkg::*;
#(
   parameter int NUM_REGS = scoreboard_pkg::NUM_REGS,
   parameter int IDX_W    = scoreboard_pkg::IDX_W
) (
   input  logic [IDX_W-1:0]    idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   // One bit set at position idx when enabled, otherwise all zero
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: issue sets, write-back clears, Stall
// blocks issue on RAW hazards (and WAW / counter capacity).
// Optional feature macro: SCOREBOARD_MULTI_PENDING_EN -- when defined each
// register keeps a saturating in-flight counter instead of a single bit.
module dest_reg_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NUM_REGS    = scoreboard_pkg::NUM_REGS,
   parameter int IDX_W       = scoreboard_pkg::IDX_W,
   parameter int MAX_PENDING = scoreboard_pkg::MAX_PENDING
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                IssueValid,
   input  logic                IssueWrites,
   input  logic [IDX_W-1:0]    IssueRegDst,
   input  logic [IDX_W-1:0]    IssueRs,
   input  logic [IDX_W-1:0]    IssueRt,
   input  logic                IssueUsesRs,
   input  logic                IssueUsesRt,
   input  logic                WbValid,
   input  logic [IDX_W-1:0]    WbRegDst,
   input  logic                Flush,
   output logic                Stall,
   output logic [NUM_REGS-1:0] Pending,
   output logic [IDX_W:0]      PendingCount,
   output logic                ErrUnderflow
);

   // Register 0 is hard-wired and never tracked
   localparam logic [NUM_REGS-1:0] TRACK_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

   logic [NUM_REGS-1:0] wb_oh;
   logic [NUM_REGS-1:0] iss_oh;
   logic [NUM_REGS-1:0] eff_pending;
   logic [NUM_REGS-1:0] pend_nxt;
   logic [IDX_W:0]      count_nxt;
   logic                raw;
   logic                capacity;
   logic                issue_acc;
   logic                underflow;

   function automatic logic [IDX_W:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [IDX_W:0] s;
      s = '0;
      for (int i = 0; i < NUM_REGS; i++) s = s + (IDX_W+1)'(v[i]);
      return s;
   endfunction

   reg_idx_decoder_5to32 #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_wb_dec (
      .idx    (WbRegDst),
      .en     (WbValid),
      .onehot (wb_oh)
   );

   reg_idx_decoder_5to32 #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_iss_dec (
      .idx    (IssueRegDst),
      .en     (issue_acc),
      .onehot (iss_oh)
   );

   // Same-cycle write-back bypass: the register file writes in the first half
   // of the cycle, so a register being written back is already safe to read
   always_comb begin
      eff_pending = Pending & ~wb_oh;
      raw = (IssueUsesRs && eff_pending[IssueRs]) ||
            (IssueUsesRt && eff_pending[IssueRt]);
   end

   assign Stall     = IssueValid && !Flush && (raw || capacity);
   assign issue_acc = IssueValid && !Stall && !Flush && IssueWrites;

`ifdef SCOREBOARD_MULTI_PENDING_EN
   localparam int CW = $clog2(MAX_PENDING + 1);

   logic [CW-1:0] cnt     [NUM_REGS];
   logic [CW-1:0] cnt_nxt [NUM_REGS];
   logic          wb_same;

   // Capacity: target counter full and not being drained this cycle
   always_comb begin
      wb_same   = WbValid && (WbRegDst == IssueRegDst);
      capacity  = IssueWrites && (cnt[IssueRegDst] == CW'(MAX_PENDING)) && !wb_same;
      underflow = WbValid && (WbRegDst != '0) && (cnt[WbRegDst] == '0);
   end

   // Decrement-then-increment per register; flush and register 0 force zero
   always_comb begin
      pend_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_nxt[i] = cnt[i];
         if (wb_oh[i] && (cnt[i] != '0)) cnt_nxt[i] = cnt_nxt[i] - 1'b1;
         if (iss_oh[i])                  cnt_nxt[i] = cnt_nxt[i] + 1'b1;
         if (Flush || (i == 0))          cnt_nxt[i] = '0;
         pend_nxt[i] = (cnt_nxt[i] != '0);
      end
   end

   // Per-register in-flight counters
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      end
   end
`else
   // Single-bit tracking: a second write to a pending register (WAW) waits
   always_comb begin
      capacity  = IssueWrites && eff_pending[IssueRegDst];
      underflow = WbValid && (WbRegDst != '0) && !Pending[WbRegDst];
      pend_nxt  = Flush ? '0 : (((Pending & ~wb_oh) | iss_oh) & TRACK_MASK);
   end
`endif

   assign count_nxt = popcount(pend_nxt & TRACK_MASK);

   // Registered pending mask, its population count and sticky underflow flag
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Pending      <= '0;
         PendingCount <= '0;
         ErrUnderflow <= 1'b0;
      end else begin
         Pending      <= pend_nxt & TRACK_MASK;
         PendingCount <= count_nxt;
         if (!Flush && underflow) ErrUnderflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Self-checking bench for dest_reg_scoreboard: a behavioural model pushes
// expected Stall and next-state into a queue as each vector is driven; they
// are popped and compared when the DUT produces them.
module tb_dest_reg_scoreboard;
   import scoreboard_pkg::*;

   logic           Clk = 1'b0;
   logic           Reset_n;
   logic           IssueValid, IssueWrites, IssueUsesRs, IssueUsesRt;
   reg_idx_t       IssueRegDst, IssueRs, IssueRt, WbRegDst;
   logic           WbValid, Flush;
   logic           Stall;
   logic [31:0]    Pending;
   logic [5:0]     PendingCount;
   logic           ErrUnderflow;

   typedef struct {
      logic        st;
      logic [31:0] pend;
      logic [5:0]  cnt;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   mc[32];
   logic merr;
   int   n_vec = 0;
   int   n_err = 0;
   logic st_obs;

   dest_reg_scoreboard dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .IssueValid(IssueValid), .IssueWrites(IssueWrites),
      .IssueRegDst(IssueRegDst), .IssueRs(IssueRs), .IssueRt(IssueRt),
      .IssueUsesRs(IssueUsesRs), .IssueUsesRt(IssueUsesRt),
      .WbValid(WbValid), .WbRegDst(WbRegDst), .Flush(Flush),
      .Stall(Stall), .Pending(Pending), .PendingCount(PendingCount),
      .ErrUnderflow(ErrUnderflow)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) mc[i] = 0;
      merr = 1'b0;
   endtask

   // Drive one cycle, predict, then compare Stall before the edge and state after it
   task automatic step(input logic iv, input logic iw, input int dst,
                       input logic urs, input int rs, input logic urt, input int rt,
                       input logic wv, input int wd, input logic fl,
                       output logic st_o);
      logic [31:0] mp, ep;
      logic        raw, cap, st, acc;
      exp_t        e, g;
      IssueValid = iv; IssueWrites = iw; IssueRegDst = 5'(dst);
      IssueUsesRs = urs; IssueRs = 5'(rs); IssueUsesRt = urt; IssueRt = 5'(rt);
      WbValid = wv; WbRegDst = 5'(wd); Flush = fl;
      for (int i = 0; i < 32; i++) mp[i] = (mc[i] != 0);
      ep = mp;
      if (wv) ep[wd] = 1'b0;
      raw = (urs && ep[rs]) || (urt && ep[rt]);
`ifdef SCOREBOARD_MULTI_PENDING_EN
      cap = iw && (mc[dst] == MAX_PENDING) && !(wv && (wd == dst));
`else
      cap = iw && ep[dst];
`endif
      st  = iv && !fl && (raw || cap);
      acc = iv && !st && !fl && iw;
      if (fl) begin
         for (int i = 0; i < 32; i++) mc[i] = 0;
      end else begin
         if (wv && (wd != 0)) begin
            if (mc[wd] == 0) merr = 1'b1;
            else mc[wd] = mc[wd] - 1;
         end
         if (acc && (dst != 0)) mc[dst] = mc[dst] + 1;
      end
      e.st = st; e.cnt = '0; e.err = merr;
      for (int i = 0; i < 32; i++) begin
         e.pend[i] = (mc[i] != 0);
         e.cnt     = e.cnt + 6'(mc[i] != 0);
      end
      exp_q.push_back(e);
      #1;
      st_o = Stall;
      g = exp_q[0];
      chk("stall", 64'(Stall), 64'(g.st));
      @(posedge Clk);
      #1;
      g = exp_q.pop_front();
      chk("pending", 64'(Pending), 64'(g.pend));
      chk("pcount", 64'(PendingCount), 64'(g.cnt));
      chk("err", 64'(ErrUnderflow), 64'(g.err));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st_obs);
   endtask

   task automatic pulse_reset();
      Reset_n = 1'b0;
      #1;
      model_clear();
      chk("rst_pending", 64'(Pending), 64'h0);
      chk("rst_pcount", 64'(PendingCount), 64'h0);
      chk("rst_err", 64'(ErrUnderflow), 64'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      Reset_n = 1'b0;
      IssueValid = 0; IssueWrites = 0; IssueRegDst = '0; IssueRs = '0; IssueRt = '0;
      IssueUsesRs = 0; IssueUsesRt = 0; WbValid = 0; WbRegDst = '0; Flush = 0;
      model_clear();
      #3;
      chk("reset_pending", 64'(Pending), 64'h0);
      chk("reset_pcount", 64'(PendingCount), 64'h0);
      chk("reset_err", 64'(ErrUnderflow), 64'h0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // Issue writing $8, then dependent reader stalls
      step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp1_pending", 64'(Pending), 64'h100);
      chk("tp1_pcount", 64'(PendingCount), 64'd1);
      step(1, 0, 0, 1, 8, 0, 0, 0, 0, 0, st_obs);
      chk("tp1_raw_stall", 64'(st_obs), 64'd1);
      step(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, st_obs);
      chk("tp1_rt_stall", 64'(st_obs), 64'd1);

      // Same-cycle WB bypass releases the reader
      step(1, 0, 0, 1, 8, 0, 0, 1, 8, 0, st_obs);
      chk("tp2_bypass", 64'(st_obs), 64'd0);
      chk("tp2_pending", 64'(Pending), 64'h0);

      // $0 is never tracked
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp3_pending", 64'(Pending), 64'h0);
      step(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, st_obs);
      chk("tp3_nostall", 64'(st_obs), 64'd0);

      // Issue and WB to $9 together, then underflow on $10
      step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, st_obs);
      step(1, 1, 9, 0, 0, 0, 0, 1, 9, 0, st_obs);
      chk("tp4_bit9", 64'(Pending[9]), 64'd1);
      chk("tp4_pcount", 64'(PendingCount), 64'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, st_obs);
      chk("tp4_err", 64'(ErrUnderflow), 64'd1);
      idle();
      chk("tp4_err_sticky", 64'(ErrUnderflow), 64'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, st_obs);

      // Flush wins over a concurrent issue
      step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, st_obs);
      step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, st_obs);
      step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp5_before", 64'(Pending), 64'h38);
      step(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, st_obs);
      chk("tp5_pending", 64'(Pending), 64'h0);
      chk("tp5_pcount", 64'(PendingCount), 64'd0);
      chk("tp5_err_kept", 64'(ErrUnderflow), 64'd1);

      // Asynchronous reset mid-operation
      step(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, st_obs);
      pulse_reset();

      // WAW / capacity on $7
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, st_obs);
`ifdef SCOREBOARD_MULTI_PENDING_EN
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp6_second", 64'(st_obs), 64'd0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp6_third", 64'(st_obs), 64'd0);
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp6_fourth_stall", 64'(st_obs), 64'd1);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, st_obs);
      chk("tp6_wb_unblock", 64'(st_obs), 64'd0);
`else
      step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, st_obs);
      chk("tp6_waw_stall", 64'(st_obs), 64'd1);
      step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, st_obs);
      chk("tp6_wb_unblock", 64'(st_obs), 64'd0);
`endif
      chk("tp6_bit7", 64'(Pending[7]), 64'd1);

      // Random traffic over a small register window
      pulse_reset();
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
              1'($urandom_range(0, 31) == 0), st_obs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
